// File: rtl/ipsmacge_pkg.sv
// rtl/ipsmacge_pkg.sv - shared encodings and constants for the ipsmacge rx path
package ipsmacge_pkg;

    // up_mspd encodings; bit 1 selects byte (GMII/RGMII 1000) vs nibble mode
    localparam logic [1:0] M10      = 2'b00;
    localparam logic [1:0] M100     = 2'b01;
    localparam logic [1:0] M1000    = 2'b10;
    localparam logic [1:0] MRESERVE = 2'b11;

    typedef enum logic [1:0] {
        STT_IDLE  = 2'd0,
        STT_HIGHN = 2'd1,
        STT_LOWN  = 2'd2
    } rx_state_e;

    localparam logic [3:0] NIB_PRM = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;
    localparam logic [7:0] DAT_PRM = 8'h55;
    localparam logic [7:0] DAT_SFD = 8'hD5;

endpackage

// File: rtl/ipsmacge_fflopx.sv
// rtl/ipsmacge_fflopx.sv - plain W-bit register with synchronous active-low reset to zero
// Ports: i_clk clock; i_rstn sync active-low reset; i_d next value; o_q registered value.
module ipsmacge_fflopx #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) r_q <= '0;
        else         r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/ipsmacge_rxnibasm.sv
// rtl/ipsmacge_rxnibasm.sv - rx nibble-to-byte assembler with SFD realignment and dribble flag
// Ports: rxclk/rst_ clock and sync active-low reset; irxd/irxdv/irxer captured PHY data;
//        up_act block enable; up_mspd speed select; ogval/ogdat/ogdv/oger byte stream to
//        the framing stage; odrib odd-nibble end pulse; oalign SFD realignment pulse.
module ipsmacge_rxnibasm #(
    parameter int         DAT_DW  = 8,
    parameter int         NIB_W   = 4,
    parameter logic [3:0] NIB_PRM = 4'h5,
    parameter logic [3:0] NIB_SFD = 4'hD
) (
    input  logic              rxclk,
    input  logic              rst_,
    input  logic [DAT_DW-1:0] irxd,
    input  logic              irxdv,
    input  logic              irxer,
    input  logic              up_act,
    input  logic [1:0]        up_mspd,
    output logic              ogval,
    output logic [DAT_DW-1:0] ogdat,
    output logic              ogdv,
    output logic              oger,
    output logic              odrib,
    output logic              oalign
);
    import ipsmacge_pkg::*;

    rx_state_e          r_state;
    logic               r_phase;
    logic               r_sfdseen;
    logic [NIB_W-1:0]   r_lown;
    logic               r_lerr;
    logic [NIB_W-1:0]   r_lasthi;   // high nibble of the most recent emitted byte

    rx_state_e          w_nstate;
    logic               w_nphase;
    logic               w_nsfdseen;
    logic [NIB_W-1:0]   w_nlown;
    logic               w_nlerr;
    logic [NIB_W-1:0]   w_nlasthi;
    logic               w_val, w_dv, w_er, w_drib, w_aln;
    logic [DAT_DW-1:0]  w_dat;
    logic [NIB_W-1:0]   w_nib;

    assign w_nib = irxd[NIB_W-1:0];

    always_comb begin
        w_nstate   = r_state;
        w_nphase   = r_phase;
        w_nsfdseen = r_sfdseen;
        w_nlown    = r_lown;
        w_nlerr    = r_lerr;
        w_nlasthi  = r_lasthi;
        w_val      = 1'b0;
        w_dv       = 1'b0;
        w_er       = 1'b0;
        w_drib     = 1'b0;
        w_aln      = 1'b0;
        w_dat      = '0;

        if (up_mspd[1]) begin
            w_val = 1'b1;
            w_dat = irxd;
            w_dv  = irxdv;
            w_er  = irxer & irxdv;
        end else begin
            case (r_state)
                STT_IDLE: begin
                    if (irxdv) begin
                        w_nlown  = w_nib;
                        w_nlerr  = irxer;
                        w_nstate = STT_HIGHN;
                    end else begin
                        // idle byte ticks keep IPG counting alive downstream
                        w_val    = r_phase;
                        w_nphase = ~r_phase;
                    end
                end
                STT_HIGHN: begin
                    w_val = 1'b1;
                    if (irxdv) begin
                        w_dv      = 1'b1;
                        w_dat     = {{(DAT_DW-2*NIB_W){1'b0}}, w_nib, r_lown};
                        w_er      = r_lerr | irxer;
                        w_nlasthi = w_nib;
                        w_nstate  = STT_LOWN;
                        if (r_lown == NIB_PRM && w_nib == NIB_SFD) w_nsfdseen = 1'b1;
                    end else begin
                        w_drib     = 1'b1;
                        w_nstate   = STT_IDLE;
                        w_nsfdseen = 1'b0;
                        w_nphase   = 1'b0;
                    end
                end
                STT_LOWN: begin
                    if (!irxdv) begin
                        w_val      = 1'b1;
                        w_nstate   = STT_IDLE;
                        w_nsfdseen = 1'b0;
                        w_nphase   = 1'b0;
                    end else if (w_nib == NIB_SFD && !r_sfdseen && r_lasthi == NIB_PRM) begin
                        // SFD landed on the low phase: emit it whole and keep pairing from here
                        w_val      = 1'b1;
                        w_dv       = 1'b1;
                        w_dat      = {{(DAT_DW-2*NIB_W){1'b0}}, NIB_SFD, NIB_PRM};
                        w_er       = irxer;
                        w_aln      = 1'b1;
                        w_nsfdseen = 1'b1;
                        w_nlasthi  = NIB_SFD;
                    end else begin
                        w_nlown  = w_nib;
                        w_nlerr  = irxer;
                        w_nstate = STT_HIGHN;
                    end
                end
                default: begin
                    w_nstate = STT_IDLE;
                    w_nphase = 1'b0;
                end
            endcase
        end

        if (!up_act) begin
            w_nstate   = STT_IDLE;
            w_nphase   = 1'b0;
            w_nsfdseen = 1'b0;
            w_nlown    = '0;
            w_nlerr    = 1'b0;
            w_nlasthi  = '0;
            w_val      = 1'b0;
            w_dv       = 1'b0;
            w_er       = 1'b0;
            w_drib     = 1'b0;
            w_aln      = 1'b0;
            w_dat      = '0;
        end
    end

    always_ff @(posedge rxclk) begin
        if (!rst_) begin
            r_state   <= STT_IDLE;
            r_phase   <= 1'b0;
            r_sfdseen <= 1'b0;
            r_lown    <= '0;
            r_lerr    <= 1'b0;
            r_lasthi  <= '0;
        end else begin
            r_state   <= w_nstate;
            r_phase   <= w_nphase;
            r_sfdseen <= w_nsfdseen;
            r_lown    <= w_nlown;
            r_lerr    <= w_nlerr;
            r_lasthi  <= w_nlasthi;
        end
    end

    ipsmacge_fflopx #(.W(DAT_DW + 5)) u_oreg (
        .i_clk  (rxclk),
        .i_rstn (rst_),
        .i_d    ({w_val, w_dv, w_er, w_drib, w_aln, w_dat}),
        .o_q    ({ogval, ogdv, oger, odrib, oalign, ogdat})
    );

endmodule

// File: tb/tb_ipsmacge_rxnibasm.sv
// tb/tb_ipsmacge_rxnibasm.sv - randomized self-checking bench for ipsmacge_rxnibasm
module tb_ipsmacge_rxnibasm;

    logic       rxclk = 1'b0;
    logic       rst_ = 1'b0;
    logic [7:0] irxd = '0;
    logic       irxdv = 1'b0;
    logic       irxer = 1'b0;
    logic       up_act = 1'b1;
    logic [1:0] up_mspd = 2'b01;
    logic       ogval, ogdv, oger, odrib, oalign;
    logic [7:0] ogdat;

    int n_vec = 0;
    int n_err = 0;

    ipsmacge_rxnibasm dut (
        .rxclk(rxclk), .rst_(rst_), .irxd(irxd), .irxdv(irxdv), .irxer(irxer),
        .up_act(up_act), .up_mspd(up_mspd), .ogval(ogval), .ogdat(ogdat),
        .ogdv(ogdv), .oger(oger), .odrib(odrib), .oalign(oalign)
    );

    always #5 rxclk = ~rxclk;

    // Reference: frame-level view. m_q holds an unpaired {err,nib}; m_inframe
    // tells idle ticks from the end-of-frame marker.
    logic [4:0] m_q[$];
    bit         m_inframe = 0;
    bit         m_phase = 0;
    bit         m_sfd = 0;
    logic [3:0] m_lasthi = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (val,dv,er,drib,aln,dat)", tag, obs, exp);
        end
    endtask

    // Expected output word {val,dv,er,drib,aln,dat[7:0]} after the next edge.
    task automatic model(input logic dv, input logic [7:0] d, input logic er,
                         output logic [12:0] e);
        logic [4:0] h;
        logic [7:0] b;
        e = '0;
        if (!rst_ || !up_act) begin
            m_q.delete(); m_inframe = 0; m_phase = 0; m_sfd = 0; m_lasthi = '0;
            return;
        end
        if (up_mspd[1]) begin
            e = {1'b1, dv, er & dv, 2'b00, d};
            return;
        end
        if (!m_inframe) begin
            if (!dv) begin
                if (m_phase) e[12] = 1'b1;
                m_phase = !m_phase;
            end else begin
                m_q.push_back({er, d[3:0]});
                m_inframe = 1;
            end
        end else if (!dv) begin
            e[12] = 1'b1;
            e[9]  = (m_q.size() != 0);
            m_q.delete(); m_inframe = 0; m_phase = 0; m_sfd = 0;
        end else if (m_q.size() != 0) begin
            h = m_q.pop_front();
            b = {d[3:0], h[3:0]};
            e = {1'b1, 1'b1, h[4] | er, 2'b00, b};
            if (b == 8'hD5) m_sfd = 1;
            m_lasthi = d[3:0];
        end else if (!m_sfd && d[3:0] == 4'hD && m_lasthi == 4'h5) begin
            e = {1'b1, 1'b1, er, 1'b0, 1'b1, 8'hD5};
            m_sfd = 1;
            m_lasthi = 4'hD;
        end else begin
            m_q.push_back({er, d[3:0]});
        end
    endtask

    task automatic step(input string tag, input logic dv, input logic [7:0] d, input logic er);
        logic [12:0] e;
        irxdv = dv; irxd = d; irxer = er;
        model(dv, d, er, e);
        @(posedge rxclk);
        #1;
        check(tag, {19'd0, ogval, ogdv, oger, odrib, oalign, ogdat}, {19'd0, e});
    endtask

    task automatic nib(input string tag, input logic [3:0] n, input logic er);
        logic [3:0] u;
        u = 4'($urandom);
        step(tag, 1'b1, {u, n}, er);
    endtask

    task automatic idle(input string tag, input int n, input bit rnd_er);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            step(tag, 1'b0, d, rnd_er ? 1'($urandom) : 1'b0);
        end
    endtask

    // npre preamble nibbles, SFD nibble, then npay payload nibbles; err_at marks a payload nibble.
    task automatic nframe(input string tag, input int npre, input int npay, input int err_at,
                          input logic [3:0] p0, input logic [3:0] p1);
        for (int i = 0; i < npre; i++) nib(tag, 4'h5, 1'b0);
        nib(tag, 4'hD, 1'b0);
        for (int i = 0; i < npay; i++) begin
            logic [3:0] n;
            n = (i == 0) ? p0 : (i == 1) ? p1 : 4'($urandom);
            nib(tag, n, (i == err_at));
        end
    endtask

    initial begin
        // reset state
        step("rst0", 1'b1, 8'hA5, 1'b1);
        step("rst1", 1'b0, 8'h00, 1'b0);
        step("rst2", 1'b1, 8'h5D, 1'b0);
        rst_ = 1'b1;
        idle("idle_er", 7, 1);

        nframe("aligned", 15, 2, -1, 4'h2, 4'h1);
        idle("ipg", 6, 0);
        nframe("misalign", 14, 8, -1, 4'h3, 4'h4);
        idle("ipg", 5, 0);
        nframe("dribble", 15, 7, -1, 4'hD, 4'h1);
        idle("ipg", 4, 0);
        nframe("after_drib", 15, 6, -1, 4'hD, 4'hD);
        idle("ipg", 5, 1);
        nframe("err3rd", 15, 10, 5, 4'h0, 4'h0);
        idle("ipg", 4, 0);

        // reset mid-frame
        nframe("rst_mid", 15, 4, -1, 4'h1, 4'h2);
        rst_ = 1'b0;
        step("rst_mid_clr", 1'b1, 8'h07, 1'b0);
        rst_ = 1'b1;
        idle("post_rst", 3, 0);
        nframe("post_rst_frm", 15, 6, -1, 4'h9, 4'h8);
        idle("ipg", 3, 0);

        // up_act drop mid-frame
        nframe("act_mid", 14, 3, -1, 4'h1, 4'h2);
        up_act = 1'b0;
        step("act_mid_clr", 1'b1, 8'h0E, 1'b1);
        step("act_off", 1'b0, 8'h00, 1'b0);
        up_act = 1'b1;
        idle("post_act", 3, 0);
        nframe("post_act_frm", 15, 6, -1, 4'h6, 4'h7);
        idle("ipg", 3, 0);

        // randomized nibble traffic, 10 and 100 encodings
        for (int f = 0; f < 40; f++) begin
            if (f == 20) begin
                up_act = 1'b0; step("mode_sw", 1'b0, 8'h00, 1'b0);
                up_mspd = 2'b00; up_act = 1'b1;
            end
            nframe("rnd_nib", $urandom_range(9, 16), $urandom_range(0, 24),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1,
                   4'($urandom), 4'($urandom));
            idle("rnd_ipg", $urandom_range(1, 8), 1);
        end

        // byte mode
        up_act = 1'b0; step("to_byte", 1'b0, 8'h00, 1'b0);
        up_mspd = 2'b10; up_act = 1'b1;
        idle("b_idle", 3, 1);
        for (int i = 0; i < 8; i++) step("b_pre", 1'b1, 8'h55, 1'b0);
        step("b_sfd", 1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 64; i++) step("b_pay", 1'b1, 8'($urandom), (i == 10));
        step("b_end", 1'b0, 8'h00, 1'b0);
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < $urandom_range(4, 30); i++)
                step("b_rnd", 1'b1, 8'($urandom), ($urandom_range(0, 15) == 0));
            idle("b_ipg", $urandom_range(1, 5), 1);
        end
        up_mspd = 2'b11;
        for (int i = 0; i < 6; i++) step("b_rsv", 1'($urandom), 8'($urandom), 1'($urandom));
        up_act = 1'b0;
        step("b_off", 1'b1, 8'hFF, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
